// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM state encoding and frame constants.
package uart_pkg;

    localparam int UART_DEFAULT_OVS = 16;
    localparam int UART_DATA_W      = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } uart_state_t;

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Oversampling tick counter for the UART receiver; flags the bit midpoint and the last tick of a bit.
module uart_rx_bit_timer #(
    parameter int OVS = 16
) (
    input  logic clk1,
    input  logic reset,
    input  logic clear,
    output logic mid,
    output logic last
);

    localparam int            TW     = (OVS > 1) ? $clog2(OVS) : 1;
    localparam logic [TW-1:0] MID_T  = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] LAST_T = TW'(OVS - 1);

    logic [TW-1:0] r_tick;

    // Explicit wrap keeps non-power-of-two OVS values exact.
    always_ff @(posedge clk1) begin
        if (reset || clear) begin
            r_tick <= '0;
        end else if (r_tick == LAST_T) begin
            r_tick <= '0;
        end else begin
            r_tick <= r_tick + 1'b1;
        end
    end

    assign mid  = (r_tick == MID_T);
    assign last = (r_tick == LAST_T);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames sampled at mid-bit, one-cycle valid/frame_err strobes.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVS    = UART_DEFAULT_OVS,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic              clk1,
    input  logic              reset,
    input  logic              rx,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              frame_err,
    output logic              busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic              parity_err
`endif
);

    localparam int            BW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    uart_state_t       r_state, w_stateNext;
    logic              r_rxMeta, r_rxSync;
    logic [DATA_W-1:0] r_shift, w_shiftNext;
    logic [BW-1:0]     r_bitCnt, w_bitCntNext;
    logic              w_loadData, w_frameErr, w_clear, w_mid, w_last;
`ifdef UART_RX_PARITY_EN
    logic              r_parityBit, w_parityBitNext, w_parityErr;
`endif

    // Two-flop synchronizer; flops reset high so the idle line is not seen as a start bit.
    always_ff @(posedge clk1) begin
        if (reset) begin
            r_rxMeta <= 1'b1;
            r_rxSync <= 1'b1;
        end else begin
            r_rxMeta <= rx;
            r_rxSync <= r_rxMeta;
        end
    end

    assign w_clear = (w_stateNext != r_state);

    uart_rx_bit_timer #(.OVS(OVS)) u_timer (
        .clk1  (clk1),
        .reset (reset),
        .clear (w_clear),
        .mid   (w_mid),
        .last  (w_last)
    );

    always_comb begin
        w_stateNext  = r_state;
        w_shiftNext  = r_shift;
        w_bitCntNext = r_bitCnt;
        w_loadData   = 1'b0;
        w_frameErr   = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_parityBitNext = r_parityBit;
`endif
        case (r_state)
            IDLE: begin
                if (!r_rxSync) w_stateNext = START;
            end
            START: begin
                if (w_mid) begin
                    w_stateNext  = r_rxSync ? IDLE : DATA;
                    w_bitCntNext = '0;
                end
            end
            DATA: begin
                if (w_last) begin
                    w_shiftNext  = {r_rxSync, r_shift[DATA_W-1:1]};
                    w_bitCntNext = r_bitCnt + 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (r_bitCnt == LAST_BIT) w_stateNext = PARITY;
`else
                    if (r_bitCnt == LAST_BIT) w_stateNext = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (w_last) begin
                    w_parityBitNext = r_rxSync;
                    w_stateNext     = STOP;
                end
            end
`endif
            STOP: begin
                if (w_last) begin
                    if (r_rxSync) begin
                        w_loadData  = 1'b1;
                        w_stateNext = IDLE;
                    end else begin
                        w_frameErr  = 1'b1;
                        w_stateNext = BREAK;
                    end
                end
            end
            BREAK: begin
                if (r_rxSync) w_stateNext = IDLE;
            end
            default: w_stateNext = IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    assign w_parityErr = w_loadData & ((^r_shift) ^ r_parityBit);
`endif

    always_ff @(posedge clk1) begin
        if (reset) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bitCnt  <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parityBit <= 1'b0;
            parity_err  <= 1'b0;
`endif
        end else begin
            r_state   <= w_stateNext;
            r_shift   <= w_shiftNext;
            r_bitCnt  <= w_bitCntNext;
            valid     <= w_loadData;
            frame_err <= w_frameErr;
            if (w_loadData) data <= r_shift;
`ifdef UART_RX_PARITY_EN
            r_parityBit <= w_parityBitNext;
            parity_err  <= w_parityErr;
`endif
        end
    end

    assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized traffic against a byte-queue model.
module tb_uart_rx;

    localparam int OVS = 16;

    logic       clk1  = 1'b0;
    logic       reset = 1'b1;
    logic       rx    = 1'b1;
    logic [7:0] data;
    logic       valid, frame_err, busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int checks = 0, failures = 0;
    int cycle = 0;
    int validCnt = 0, ferrCnt = 0, overlapCnt = 0, perrCnt = 0, perrAlone = 0;
    int lastValidCycle = 0;
    logic [7:0] obsQ[$];
    logic [7:0] expQ[$];

    uart_rx #(.OVS(OVS), .DATA_W(8)) dut (
        .clk1      (clk1),
        .reset     (reset),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk1 = ~clk1;

    always @(posedge clk1) cycle++;

    // Monitor: record every strobe away from the active edge.
    always @(negedge clk1) begin
        if (valid) begin
            validCnt++;
            obsQ.push_back(data);
            lastValidCycle = cycle;
        end
        if (frame_err) ferrCnt++;
        if (valid && frame_err) overlapCnt++;
`ifdef UART_RX_PARITY_EN
        if (parity_err) perrCnt++;
        if (parity_err && !valid) perrAlone++;
`endif
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk1);
    endtask

    task automatic driveBit(input logic b);
        rx = b;
        repeat (OVS) @(negedge clk1);
    endtask

    // Full serial frame; parityFlip inverts the even-parity bit when parity is built in.
    task automatic applyStimulus(input logic [7:0] b, input logic stopBit, input logic parityFlip);
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) driveBit(b[i]);
`ifdef UART_RX_PARITY_EN
        driveBit((^b) ^ parityFlip);
`else
        if (parityFlip) rx = 1'b1;
`endif
        driveBit(stopBit);
    endtask

    initial begin
        int baseV, baseF, baseP, startCycle, lat, expFerr;
        logic [7:0] b, frame5A;

        // Reset state
        idle(3);
        checkOutput("reset_data", data, 0);
        checkOutput("reset_valid", valid, 0);
        checkOutput("reset_frame_err", frame_err, 0);
        checkOutput("reset_busy", busy, 0);
        reset = 1'b0;
        idle(5);

        // Single good frame 0xA5
        baseV = validCnt; baseF = ferrCnt; obsQ.delete();
        startCycle = cycle;
        applyStimulus(8'hA5, 1'b1, 1'b0);
        idle(4);
        lat = lastValidCycle - startCycle;
        checkOutput("a5_valid_count", validCnt - baseV, 1);
        checkOutput("a5_data", data, 8'hA5);
        checkOutput("a5_frame_err", ferrCnt - baseF, 0);
        checkOutput("a5_latency_window", (lat >= 150 && lat <= 158), 1);
        checkOutput("a5_busy_after", busy, 0);

        // False start: short low glitch
        baseV = validCnt; baseF = ferrCnt;
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(1);
        checkOutput("false_start_busy_high", busy, 1);
        idle(7);
        checkOutput("false_start_busy_low", busy, 0);
        idle(200);
        checkOutput("false_start_no_valid", validCnt - baseV, 0);
        checkOutput("false_start_no_ferr", ferrCnt - baseF, 0);

        // Framing error with held-low line
        baseV = validCnt; baseF = ferrCnt;
        applyStimulus(8'h3C, 1'b0, 1'b0);
        idle(24);
        checkOutput("break_busy_held", busy, 1);
        rx = 1'b1;
        idle(6);
        checkOutput("break_busy_released", busy, 0);
        checkOutput("break_ferr_count", ferrCnt - baseF, 1);
        checkOutput("break_no_valid", validCnt - baseV, 0);
        checkOutput("break_data_kept", data, 8'hA5);

        // Back-to-back frames, zero idle gap
        baseV = validCnt; obsQ.delete();
        applyStimulus(8'h00, 1'b1, 1'b0);
        applyStimulus(8'hFF, 1'b1, 1'b0);
        idle(4);
        checkOutput("b2b_valid_count", validCnt - baseV, 2);
        checkOutput("b2b_first", (obsQ.size() > 0) ? obsQ[0] : 8'hxx, 8'h00);
        checkOutput("b2b_second", (obsQ.size() > 1) ? obsQ[1] : 8'hxx, 8'hFF);

        // Reset during bit 4 of 0x5A
        baseV = validCnt; baseF = ferrCnt; obsQ.delete();
        frame5A = 8'h5A;
        driveBit(1'b0);
        for (int i = 0; i < 4; i++) driveBit(frame5A[i]);
        rx = frame5A[4];
        idle(8);
        reset = 1'b1;
        idle(2);
        checkOutput("midreset_data", data, 0);
        checkOutput("midreset_valid", valid, 0);
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_frame_err", frame_err, 0);
        rx = 1'b1;
        reset = 1'b0;
        idle(200);
        checkOutput("midreset_no_valid", validCnt - baseV, 0);
        checkOutput("midreset_no_ferr", ferrCnt - baseF, 0);
        applyStimulus(8'h81, 1'b1, 1'b0);
        idle(4);
        checkOutput("after_reset_valid", validCnt - baseV, 1);
        checkOutput("after_reset_data", data, 8'h81);

`ifdef UART_RX_PARITY_EN
        // Even parity good, then bad
        baseV = validCnt; baseP = perrCnt;
        applyStimulus(8'h07, 1'b1, 1'b0);
        idle(4);
        checkOutput("parity_good_valid", validCnt - baseV, 1);
        checkOutput("parity_good_no_err", perrCnt - baseP, 0);
        applyStimulus(8'h07, 1'b1, 1'b1);
        idle(4);
        checkOutput("parity_bad_valid", validCnt - baseV, 2);
        checkOutput("parity_bad_err", perrCnt - baseP, 1);
        checkOutput("parity_bad_data", data, 8'h07);
`endif

        // Randomized traffic against a queue of expected bytes
        baseF = ferrCnt; baseP = perrCnt; obsQ.delete(); expQ.delete(); expFerr = 0;
        for (int n = 0; n < 24; n++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                applyStimulus(b, 1'b0, 1'b0);
                idle($urandom_range(0, 20));
                rx = 1'b1;
                idle($urandom_range(4, 20));
                expFerr++;
            end else begin
                applyStimulus(b, 1'b1, 1'b0);
                expQ.push_back(b);
                idle($urandom_range(0, 12));
            end
        end
        idle(20);
        checkOutput("rand_frame_count", obsQ.size(), expQ.size());
        for (int i = 0; i < expQ.size(); i++) begin
            checkOutput($sformatf("rand_byte_%0d", i), (i < obsQ.size()) ? obsQ[i] : 8'hxx, expQ[i]);
        end
        checkOutput("rand_ferr_count", ferrCnt - baseF, expFerr);
        checkOutput("rand_no_parity_err", perrCnt - baseP, 0);

        checkOutput("valid_ferr_never_overlap", overlapCnt, 0);
        checkOutput("parity_err_only_with_valid", perrAlone, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
